uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, is the maximum number of cycles the block waits in SEND or HOLD; it is used only when UART_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  req[i]: requester i has a byte pending; held with its data until ack[i].
REQ-005 req_data  input  32  byte of requester i on bits [8i+7:8i].
REQ-006 req_last  input  4  req_last[i]: the pending byte is the last of a message.
REQ-007 ack  output  4  one-cycle pulse: requester i's byte has been captured.
REQ-008 done  output  4  one-cycle pulse: requester i's byte has finished transmitting.
REQ-009 tx_en_sig  output  1  enable to the UART transmit controller.
REQ-010 tx_data  output  8  registered byte presented to the transmitter.
REQ-011 tx_done_sig  input  1  completion pulse from the transmitter.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 grant_id  output  2  index of the current owner; holds its last value in IDLE.
REQ-014 timeout  output  1  one-cycle abort pulse; tied 0 without UART_ARB_TIMEOUT_EN.

Function
REQ-015 States are IDLE, SEND and HOLD; all outputs are registered.
REQ-016 IDLE transitions:
- If any req bit is set at edge N, select the winner round-robin, starting from pointer rr_ptr.
- At N+1: tx_data = winner's byte; ack[winner] = 1; tx_en_sig = 1; grant_id = winner; state = SEND.
- The winner's req_last is latched as last_flag.
REQ-017 SEND transitions:
- tx_en_sig stays 1 until tx_done_sig is sampled high at edge M.
- At M+1: tx_en_sig = 0 and done[owner] = 1.
- Next state is IDLE if last_flag = 1, otherwise HOLD.
REQ-018 When leaving to IDLE, rr_ptr SHALL become (owner+1) mod 4.
REQ-019 HOLD transitions:
- Only req[owner] is honoured; other requesters stay unserved.
- On req[owner] = 1: capture the byte, pulse ack[owner], set tx_en_sig = 1 and relatch last_flag one cycle later, and go to SEND.
REQ-020 tx_en_sig SHALL be 0 for at least one cycle between consecutive bytes: after done, the earliest next ack/tx_en_sig rise is at M+2.
REQ-021 tx_done_sig SHALL be ignored in IDLE and HOLD.
REQ-022 Changes to req or req_data after ack SHALL have no effect on the byte in flight.
REQ-023 At most one ack bit and at most one done bit SHALL be set in any cycle.
REQ-024 If req sets in the same cycle the state returns to IDLE, that request SHALL be arbitrated on the next edge using the updated rr_ptr.
REQ-025 tx_data SHALL hold its value until the next capture.

Reset
REQ-026 When rst is sampled high, the block SHALL go to IDLE, including mid-transmission.
REQ-027 Reset values:
- tx_en_sig = 0, tx_data = 0, ack = 0, done = 0, timeout = 0
- busy = 0, grant_id = 0, rr_ptr = 0, last_flag = 0, timeout counter = 0
REQ-028 A byte aborted by reset SHALL produce no done pulse.

Configuration
REQ-029 Macro UART_ARB_TIMEOUT_EN defined:
- A counter clears on every entry to SEND or HOLD and increments every cycle in those states.
- When it reaches TIMEOUT_CYCLES-1 without tx_done_sig (SEND) or req[owner] (HOLD), the next edge sets tx_en_sig = 0 and timeout = 1 for one cycle, and gives no done pulse.
- The lock is released, rr_ptr = owner+1 and the state goes to IDLE.
- The counter width is ceil(log2(TIMEOUT_CYCLES)) bits.
REQ-030 Macro UART_ARB_TIMEOUT_EN undefined:
- No counter logic; timeout is constant 0.
- SEND and HOLD wait indefinitely.

Verification
REQ-031 Scenario, single byte:
- Stimulus: req=0001, req_data[7:0]=0x55, req_last=0001; tx_done_sig pulsed 10 cycles after tx_en_sig rises.
- Response: ack=0001 one cycle after req; tx_data=0x55; done=0001 one cycle after tx_done_sig; tx_en_sig low the same cycle as done; busy=0 afterwards.
REQ-032 Scenario, contention:
- Stimulus: req=1111 held, all req_last=1.
- Response: grant order 0,1,2,3,0; one ack per byte; tx_en_sig low ≥1 cycle between bytes.
REQ-033 Scenario, message lock:
- Stimulus: requester 2 sends bytes 0xA1, 0xA2 (req_last=1 on 0xA2) while req[0] is held high.
- Response: both bytes are sent with grant_id=2; requester 0 is acked only after done[2] for 0xA2.
REQ-034 Scenario, reset mid-byte:
- Stimulus: rst=1 for one cycle during SEND.
- Response: next cycle tx_en_sig=0, busy=0, grant_id=0, no done pulse; then req=0100 gives grant_id=2.
REQ-035 Scenario, timeout (with UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16):
- Stimulus: tx_done_sig held 0 during SEND.
- Response: timeout=1 exactly 16 cycles after ack, tx_en_sig=0, no done, state IDLE.
- Without the macro, tx_en_sig stays 1 for 1000 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signal bundle for uart_tx_arbiter
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        tx_en_sig;
    logic [7:0]  tx_data;
    logic        tx_done_sig;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout;

    // Arbiter side
    modport slave (
        input  req, req_data, req_last, tx_done_sig,
        output ack, done, tx_en_sig, tx_data, busy, grant_id, timeout
    );

    // Requester / transmitter side
    modport master (
        output req, req_data, req_last, tx_done_sig,
        input  ack, done, tx_en_sig, tx_data, busy, grant_id, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - 4-way round-robin UART TX arbiter with message lock (optional watchdog: UART_ARB_TIMEOUT_EN)
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] ack_q, ack_d;
    logic [3:0] done_q, done_d;
    logic       tx_en_q, tx_en_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       busy_q, busy_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic       last_q, last_d;
    logic       abort_d;
    logic       expired;

    logic       rr_hit;
    logic [1:0] rr_winner;
    logic       cap_en;
    logic [1:0] cap_id;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;

    assign expired = (cnt_q == CNT_MAX);

    // Watchdog: restart on every entry to SEND/HOLD, count while waiting there
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == IDLE) begin
            cnt_d = '0;
        end else if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= abort_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign expired            = 1'b0;
    assign unused_timeout_cfg = ^{abort_d, TIMEOUT_CYCLES};
    assign bus.timeout        = 1'b0;
`endif

    // Round-robin search starting at rr_ptr_q
    always_comb begin
        rr_hit    = 1'b0;
        rr_winner = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!rr_hit && bus.req[rr_ptr_q + 2'(k)]) begin
                rr_hit    = 1'b1;
                rr_winner = rr_ptr_q + 2'(k);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        ack_d     = '0;
        done_d    = '0;
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        last_d    = last_q;
        abort_d   = 1'b0;
        cap_en    = 1'b0;
        cap_id    = grant_q;

        case (state_q)
            IDLE: begin
                if (rr_hit) begin
                    cap_en = 1'b1;
                    cap_id = rr_winner;
                end
            end
            SEND: begin
                if (bus.tx_done_sig) begin
                    tx_en_d         = 1'b0;
                    done_d[grant_q] = 1'b1;
                    if (last_q) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_q + 2'd1;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (expired) begin
                    tx_en_d  = 1'b0;
                    abort_d  = 1'b1;
                    state_d  = IDLE;
                    rr_ptr_d = grant_q + 2'd1;
                end
            end
            HOLD: begin
                // Message lock: only the current owner may continue
                if (bus.req[grant_q]) begin
                    cap_en = 1'b1;
                    cap_id = grant_q;
                end else if (expired) begin
                    abort_d  = 1'b1;
                    state_d  = IDLE;
                    rr_ptr_d = grant_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cap_en) begin
            tx_data_d     = bus.req_data[{cap_id, 3'b000} +: 8];
            ack_d[cap_id] = 1'b1;
            tx_en_d       = 1'b1;
            grant_d       = cap_id;
            last_d        = bus.req_last[cap_id];
            state_d       = SEND;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ack_q     <= '0;
            done_q    <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            last_q    <= last_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.done      = done_q;
    assign bus.tx_en_sig = tx_en_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: phase 0 = free, 1 = byte on the wire, 2 = owner's message still open
    int         m_phase = 0;
    int         m_owner = 0;
    int         m_ptr   = 0;
    int         m_wait  = 0;
    logic [7:0] m_data  = 8'h00;
    logic       m_last  = 1'b0;

    logic [3:0] e_ack, e_done;
    logic       e_txen, e_busy, e_to;
    logic [1:0] e_grant;
    logic [7:0] e_data;

    // Transmitter stub state
    bit armed = 0;
    int cd    = 0;

    typedef struct packed { logic [7:0] d; logic l; } item_t;
    item_t q[4][$];

    typedef struct { int pre; logic [3:0] req; int exp; } arb_vec_t;
    arb_vec_t vt[8];

    int         order[$];
    int         waited, low, found;
    logic [3:0] acc;
    item_t      it;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic m_capture(input int i);
        m_owner = i;
        m_data  = bus.req_data[8*i +: 8];
        m_last  = bus.req_last[i];
        e_ack   = 4'(1 << i);
        m_phase = 1;
        m_wait  = 0;
    endtask

    task automatic m_waiting();
`ifdef UART_ARB_TIMEOUT_EN
        m_wait++;
        if (m_wait == TO) begin
            e_to    = 1'b1;
            m_phase = 0;
            m_ptr   = (m_owner + 1) % 4;
        end
`endif
    endtask

    task automatic model_advance();
        int  i;
        bit  hit;
        e_ack  = '0;
        e_done = '0;
        e_to   = 1'b0;
        if (rst) begin
            m_phase = 0; m_owner = 0; m_ptr = 0; m_wait = 0; m_data = 8'h00; m_last = 1'b0;
        end else if (m_phase == 0) begin
            hit = 0;
            for (int k = 0; k < 4; k++) begin
                i = (m_ptr + k) % 4;
                if (!hit && bus.req[i]) begin
                    hit = 1;
                    m_capture(i);
                end
            end
        end else if (m_phase == 1) begin
            if (bus.tx_done_sig) begin
                e_done = 4'(1 << m_owner);
                if (m_last) begin
                    m_phase = 0;
                    m_ptr   = (m_owner + 1) % 4;
                end else begin
                    m_phase = 2;
                    m_wait  = 0;
                end
            end else begin
                m_waiting();
            end
        end else begin
            if (bus.req[m_owner]) m_capture(m_owner);
            else                  m_waiting();
        end
        e_txen  = (m_phase == 1);
        e_busy  = (m_phase != 0);
        e_grant = 2'(m_owner);
        e_data  = m_data;
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
        chk("ack",      bus.ack,       e_ack);
        chk("done",     bus.done,      e_done);
        chk("tx_en",    bus.tx_en_sig, e_txen);
        chk("tx_data",  bus.tx_data,   e_data);
        chk("busy",     bus.busy,      e_busy);
        chk("grant_id", bus.grant_id,  e_grant);
        chk("timeout",  bus.timeout,   e_to);
    endtask

    task automatic xmit(input bit spur);
        bus.tx_done_sig = 1'b0;
        if (bus.tx_en_sig) begin
            if (!armed) begin
                armed = 1;
                cd    = $urandom_range(0, 4);
            end
            if (cd == 0) begin
                bus.tx_done_sig = 1'b1;
                armed           = 0;
            end else begin
                cd--;
            end
        end else begin
            armed = 0;
            if (spur) bus.tx_done_sig = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_done_sig = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_byte(input int id, input logic [7:0] d, input logic l);
        bus.req      = 4'(1 << id);
        bus.req_data = 32'(d) << (8 * id);
        bus.req_last = 4'(l) << id;
        tick();
        bus.req = '0;
        tick();
        bus.tx_done_sig = 1'b1;
        tick();
        bus.tx_done_sig = 1'b0;
    endtask

    initial begin
        vt[0] = '{-1, 4'b0001, 0};
        vt[1] = '{-1, 4'b1010, 1};
        vt[2] = '{-1, 4'b1000, 3};
        vt[3] = '{ 0, 4'b1111, 1};
        vt[4] = '{ 2, 4'b1011, 3};
        vt[5] = '{ 3, 4'b0110, 1};
        vt[6] = '{ 1, 4'b0001, 0};
        vt[7] = '{ 3, 4'b1000, 3};

        // Reset state
        do_reset();
        tick();
        chk("rst_busy",  bus.busy,      0);
        chk("rst_txen",  bus.tx_en_sig, 0);
        chk("rst_data",  bus.tx_data,   0);
        chk("rst_grant", bus.grant_id,  0);

        // Single byte
        bus.req = 4'b0001; bus.req_data = 32'h0000_0055; bus.req_last = 4'b0001;
        tick();
        chk("s1_ack",  bus.ack,       4'b0001);
        chk("s1_data", bus.tx_data,   8'h55);
        chk("s1_txen", bus.tx_en_sig, 1);
        bus.req = '0; bus.req_data = 32'hDEAD_BEEF;
        repeat (9) tick();
        bus.tx_done_sig = 1'b1;
        tick();
        bus.tx_done_sig = 1'b0;
        chk("s1_done",    bus.done,      4'b0001);
        chk("s1_txen_lo", bus.tx_en_sig, 0);
        chk("s1_hold",    bus.tx_data,   8'h55);
        tick();
        chk("s1_busy", bus.busy, 0);

        // Arbitration table
        for (int v = 0; v < 8; v++) begin
            do_reset();
            if (vt[v].pre >= 0) send_byte(vt[v].pre, 8'(8'h80 + vt[v].pre), 1'b1);
            bus.req = vt[v].req; bus.req_data = 32'h1312_1110; bus.req_last = '1;
            tick();
            chk("tbl_grant", bus.grant_id, vt[v].exp);
            chk("tbl_ack",   bus.ack,      32'(1) << vt[v].exp);
            chk("tbl_data",  bus.tx_data,  32'h10 + vt[v].exp);
            bus.req = '0;
            tick();
            bus.tx_done_sig = 1'b1;
            tick();
            bus.tx_done_sig = 1'b0;
            tick();
        end

        // Contention, all requesters hold single-byte messages
        do_reset();
        bus.req = '1; bus.req_data = 32'h3322_1100; bus.req_last = '1;
        order.delete();
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            tick();
            for (int i = 0; i < 4; i++) if (bus.ack[i]) order.push_back(i);
            xmit(0);
        end
        chk("cont_count", order.size(), 5);
        if (order.size() == 5) begin
            chk("cont_g0", order[0], 0);
            chk("cont_g1", order[1], 1);
            chk("cont_g2", order[2], 2);
            chk("cont_g3", order[3], 3);
            chk("cont_g4", order[4], 0);
        end

        // Message lock: requester 2 keeps the transmitter while requester 0 waits
        do_reset();
        bus.req = 4'b0100; bus.req_data = 32'h00A1_0030; bus.req_last = 4'b0001;
        tick();
        chk("lock_ack1", bus.ack, 4'b0100);
        bus.req = 4'b0001;
        repeat (3) tick();
        bus.tx_done_sig = 1'b1;
        tick();
        bus.tx_done_sig = 1'b0;
        chk("lock_done1", bus.done, 4'b0100);
        acc = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            acc |= bus.ack;
        end
        chk("lock_hold", acc, 4'b0000);
        bus.req = 4'b0101; bus.req_data = 32'h00A2_0030; bus.req_last = 4'b0101;
        tick();
        chk("lock_ack2",   bus.ack,      4'b0100);
        chk("lock_grant2", bus.grant_id, 2);
        chk("lock_data2",  bus.tx_data,  8'hA2);
        bus.req = 4'b0001;
        repeat (2) tick();
        bus.tx_done_sig = 1'b1;
        tick();
        bus.tx_done_sig = 1'b0;
        chk("lock_done2", bus.done, 4'b0100);
        chk("lock_ack0_early", bus.ack, 4'b0000);
        tick();
        chk("lock_ack0",   bus.ack,      4'b0001);
        chk("lock_grant0", bus.grant_id, 0);
        bus.req = '0;
        tick();
        bus.tx_done_sig = 1'b1;
        tick();
        bus.tx_done_sig = 1'b0;
        tick();

        // Reset in the middle of a byte
        do_reset();
        bus.req = 4'b0010; bus.req_data = 32'h0000_4400; bus.req_last = 4'b0010;
        tick();
        bus.req = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_txen",  bus.tx_en_sig, 0);
        chk("mid_busy",  bus.busy,      0);
        chk("mid_grant", bus.grant_id,  0);
        chk("mid_done",  bus.done,      0);
        bus.tx_done_sig = 1'b1;
        tick();
        bus.tx_done_sig = 1'b0;
        chk("mid_nodone", bus.done, 0);
        bus.req = 4'b0100; bus.req_data = 32'h0066_0000; bus.req_last = 4'b0100;
        tick();
        chk("mid_grant2", bus.grant_id, 2);
        bus.req = '0;
        tick();
        bus.tx_done_sig = 1'b1;
        tick();
        bus.tx_done_sig = 1'b0;
        tick();

        // Transmitter never completes
        do_reset();
        bus.req = 4'b0001; bus.req_data = 32'h0000_0077; bus.req_last = 4'b0001;
        tick();
        bus.req = '0;
`ifdef UART_ARB_TIMEOUT_EN
        waited = 0; found = 0;
        for (int c = 1; c <= 40 && found == 0; c++) begin
            tick();
            if (bus.timeout) begin
                found  = 1;
                waited = c;
            end
        end
        chk("to_delay", waited, TO);
        chk("to_txen",  bus.tx_en_sig, 0);
        chk("to_done",  bus.done,      0);
        chk("to_busy",  bus.busy,      0);
`else
        low = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (!bus.tx_en_sig) low++;
        end
        chk("noto_txen_low", low, 0);
        chk("noto_busy", bus.busy, 1);
        bus.tx_done_sig = 1'b1;
        tick();
        bus.tx_done_sig = 1'b0;
        chk("noto_done", bus.done, 4'b0001);
`endif
        tick();

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 4; i++) q[i].delete();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        it.d = 8'($urandom);
                        it.l = (b == len - 1);
                        q[i].push_back(it);
                    end
                end
                if (!bus.req[i] && q[i].size() > 0 && $urandom_range(0, 3) != 0) begin
                    bus.req[i]             = 1'b1;
                    bus.req_data[8*i +: 8] = q[i][0].d;
                    bus.req_last[i]        = q[i][0].l;
                end
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i]) begin
                    void'(q[i].pop_front());
                    bus.req[i]             = 1'b0;
                    bus.req_data[8*i +: 8] = 8'($urandom);
                    bus.req_last[i]        = 1'($urandom);
                end
            end
            xmit(1);
            rst = ($urandom_range(0, 499) == 0);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
